// File: rtl/pc_gen_if.sv
// pc_gen_if: fetch-stage PC generator bus (stall/redirect inputs, fetch address/request outputs).
// Carries align_err_o only when PC_ALIGN_CHK_EN is defined.
interface pc_gen_if #(
    parameter int ADDR_W  = 32,
    parameter int STALL_W = 4
);
    logic [STALL_W-1:0] stall_i;
    logic               branch_enable_i;
    logic [ADDR_W-1:0]  branch_addr_i;
    logic               exc_enable_i;
    logic [ADDR_W-1:0]  exc_addr_i;
    logic               inst_addr_ok_i;
    logic [ADDR_W-1:0]  pc_o;
    logic               ce;
    logic               inst_req_o;
    logic               redirect_pend_o;
`ifdef PC_ALIGN_CHK_EN
    logic               align_err_o;
`endif
    modport master (
        output stall_i, branch_enable_i, branch_addr_i, exc_enable_i, exc_addr_i, inst_addr_ok_i,
`ifdef PC_ALIGN_CHK_EN
        input  align_err_o,
`endif
        input  pc_o, ce, inst_req_o, redirect_pend_o
    );
    modport slave (
        input  stall_i, branch_enable_i, branch_addr_i, exc_enable_i, exc_addr_i, inst_addr_ok_i,
`ifdef PC_ALIGN_CHK_EN
        output align_err_o,
`endif
        output pc_o, ce, inst_req_o, redirect_pend_o
    );
endinterface

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with exception/branch redirect, stall and pending-redirect latch.
// Optional PC_ALIGN_CHK_EN: force-aligns redirect targets and pulses align_err_o.
module pc_gen #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hbfc0_0000),
    parameter int                PC_INC   = 4,
    parameter int                STALL_W  = 4
) (
    input logic   clk,
    input logic   rst,
    pc_gen_if.slave bus
);
    localparam logic [0:0] HOLD = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
`ifdef PC_ALIGN_CHK_EN
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << $clog2(PC_INC)) - 1);
`endif

    function automatic logic [ADDR_W-1:0] fix(input logic [ADDR_W-1:0] a);
`ifdef PC_ALIGN_CHK_EN
        return a & ALIGN_MASK;
`else
        return a;
`endif
    endfunction

    logic [0:0]        state_q;
    logic [ADDR_W-1:0] pc_q, pc_d, pend_addr_q, pend_addr_d;
    logic              pend_valid_q, pend_valid_d;
    logic              run, stall_any, advance, exc, br, latch;

    always_comb begin
        run          = state_q == RUN;
        stall_any    = |bus.stall_i;
        advance      = run & ~stall_any & bus.inst_addr_ok_i;
        exc          = run & bus.exc_enable_i;
        br           = run & bus.branch_enable_i & ~exc;
        latch        = br & ~advance;
        pc_d         = exc ? fix(bus.exc_addr_i) :
                       (advance & bus.branch_enable_i) ? fix(bus.branch_addr_i) :
                       (advance & pend_valid_q) ? pend_addr_q :
                       advance ? pc_q + ADDR_W'(PC_INC) : pc_q;
        pend_valid_d = latch | (pend_valid_q & ~exc & ~advance);
        pend_addr_d  = latch ? fix(bus.branch_addr_i) : (exc | advance) ? '0 : pend_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HOLD;
            pc_q         <= RESET_PC;
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            state_q      <= RUN;
            pc_q         <= pc_d;
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

`ifdef PC_ALIGN_CHK_EN
    logic align_err_q;
    // Pending targets were aligned when latched, so only fresh exc/branch targets can be misaligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) align_err_q <= 1'b0;
        else     align_err_q <= (exc & |(bus.exc_addr_i & ~ALIGN_MASK)) |
                                (br & |(bus.branch_addr_i & ~ALIGN_MASK));
    end
    assign bus.align_err_o = align_err_q;
`endif

    assign bus.pc_o            = pc_q;
    assign bus.ce              = run;
    assign bus.inst_req_o      = run & ~stall_any;
    assign bus.redirect_pend_o = pend_valid_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed checks of pc_gen reset, sequencing, stall/pending, exception, handshake, wrap.
module tb_pc_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    pc_gen_if #(.ADDR_W(32), .STALL_W(4)) bus ();
    pc_gen dut (.clk(clk), .rst(rst), .bus(bus.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        bus.stall_i = '0; bus.branch_enable_i = 0; bus.branch_addr_i = '0;
        bus.exc_enable_i = 0; bus.exc_addr_i = '0; bus.inst_addr_ok_i = 1;
        @(negedge clk);
        chk("rst_pc", bus.pc_o, 32'hbfc00000);
        chk("rst_ce", bus.ce, 0);
        chk("rst_req", bus.inst_req_o, 0);
        chk("rst_pend", bus.redirect_pend_o, 0);
`ifdef PC_ALIGN_CHK_EN
        chk("rst_align", bus.align_err_o, 0);
`endif
        rst = 0;
        #1 chk("hold_ce", bus.ce, 0);
        chk("hold_pc", bus.pc_o, 32'hbfc00000);
        @(negedge clk);
        chk("run_ce", bus.ce, 1);
        chk("run_req", bus.inst_req_o, 1);
        chk("run_pc0", bus.pc_o, 32'hbfc00000);
        @(negedge clk) chk("seq_pc1", bus.pc_o, 32'hbfc00004);
        @(negedge clk) chk("seq_pc2", bus.pc_o, 32'hbfc00008);
        // branch arrives in first of three stall cycles
        bus.stall_i = 4'b0100; bus.branch_enable_i = 1; bus.branch_addr_i = 32'h80001000;
        @(negedge clk);
        chk("stall1_pend", bus.redirect_pend_o, 1);
        chk("stall1_pc", bus.pc_o, 32'hbfc00008);
        chk("stall1_req", bus.inst_req_o, 0);
        chk("stall1_ce", bus.ce, 1);
        bus.branch_enable_i = 0;
        @(negedge clk) chk("stall2_pc", bus.pc_o, 32'hbfc00008);
        @(negedge clk);
        chk("stall3_pc", bus.pc_o, 32'hbfc00008);
        chk("stall3_pend", bus.redirect_pend_o, 1);
        bus.stall_i = '0;
        @(negedge clk);
        chk("pend_apply_pc", bus.pc_o, 32'h80001000);
        chk("pend_apply_clr", bus.redirect_pend_o, 0);
        // exception beats stall and not-ok, clears pending
        bus.stall_i = 4'b1000; bus.inst_addr_ok_i = 0;
        bus.branch_enable_i = 1; bus.branch_addr_i = 32'h12345678;
        @(negedge clk);
        chk("exc_pre_pend", bus.redirect_pend_o, 1);
        chk("exc_pre_pc", bus.pc_o, 32'h80001000);
        bus.branch_enable_i = 0; bus.exc_enable_i = 1; bus.exc_addr_i = 32'hbfc00380;
        @(negedge clk);
        chk("exc_pc", bus.pc_o, 32'hbfc00380);
        chk("exc_pend", bus.redirect_pend_o, 0);
        bus.exc_addr_i = 32'hbfc00010;
        @(negedge clk) chk("exc2_pc", bus.pc_o, 32'hbfc00010);
        // handshake backpressure
        bus.exc_enable_i = 0; bus.stall_i = '0; bus.inst_addr_ok_i = 0;
        @(negedge clk);
        chk("bp1_pc", bus.pc_o, 32'hbfc00010);
        chk("bp1_req", bus.inst_req_o, 1);
        @(negedge clk) chk("bp2_pc", bus.pc_o, 32'hbfc00010);
        bus.inst_addr_ok_i = 1;
        @(negedge clk) chk("bp_ok_pc", bus.pc_o, 32'hbfc00014);
        // new branch at same edge as pending apply wins
        bus.stall_i = 4'b0001; bus.branch_enable_i = 1; bus.branch_addr_i = 32'h00001000;
        @(negedge clk) chk("nw_pend", bus.redirect_pend_o, 1);
        bus.stall_i = '0; bus.branch_addr_i = 32'h00002000;
        @(negedge clk);
        chk("nw_pc", bus.pc_o, 32'h00002000);
        chk("nw_pend_clr", bus.redirect_pend_o, 0);
        bus.branch_enable_i = 0;
        // wrap
        bus.exc_enable_i = 1; bus.exc_addr_i = 32'hfffffffc;
        @(negedge clk) chk("wrap_pre", bus.pc_o, 32'hfffffffc);
        bus.exc_enable_i = 0;
        @(negedge clk) chk("wrap_pc", bus.pc_o, 32'h00000000);
        // async reset mid-stall with a pending branch
        bus.stall_i = 4'b0010; bus.branch_enable_i = 1; bus.branch_addr_i = 32'h00004000;
        @(negedge clk) chk("ar_pre_pend", bus.redirect_pend_o, 1);
        bus.branch_enable_i = 0;
        #2 rst = 1;
        #1;
        chk("ar_pc", bus.pc_o, 32'hbfc00000);
        chk("ar_ce", bus.ce, 0);
        chk("ar_pend", bus.redirect_pend_o, 0);
        chk("ar_req", bus.inst_req_o, 0);
        // exception and branch during HOLD are ignored
        @(negedge clk);
        rst = 0; bus.stall_i = '0; bus.exc_enable_i = 1; bus.exc_addr_i = 32'h00000100;
        bus.branch_enable_i = 1; bus.branch_addr_i = 32'h00000200;
        @(negedge clk);
        chk("hold_exc_pc", bus.pc_o, 32'hbfc00000);
        chk("hold_br_pend", bus.redirect_pend_o, 0);
        chk("hold_exit_ce", bus.ce, 1);
        bus.exc_enable_i = 0; bus.branch_addr_i = 32'h80000006;
        @(negedge clk);
`ifdef PC_ALIGN_CHK_EN
        chk("align_pc", bus.pc_o, 32'h80000004);
        chk("align_err", bus.align_err_o, 1);
`else
        chk("verbatim_pc", bus.pc_o, 32'h80000006);
`endif
        bus.branch_enable_i = 0;
        @(negedge clk);
`ifdef PC_ALIGN_CHK_EN
        chk("align_pulse_end", bus.align_err_o, 0);
        chk("align_next_pc", bus.pc_o, 32'h80000008);
`else
        chk("verbatim_next_pc", bus.pc_o, 32'h8000000a);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
